// File: rtl/load_store_unit.sv
// MEM-stage load/store controller for a byte-addressed, big-endian data memory.
// Word stores write once; sub-word stores read, merge the addressed lane, then write.
module load_store_unit #(
  parameter int MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        fault,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_readData
);

  // Bit 2 is the write strobe and bit 1 the read strobe, so both leave a flop directly.
  typedef enum logic [2:0] {
    IDLE = 3'b000,
    RD   = 3'b010,
    MRG  = 3'b001,
    WR   = 3'b100
  } state_t;

  state_t      state, stateNext;
  logic        respValidNext, faultNext;
  logic [1:0]  offsetReg, sizeReg;
  logic        signedReg, writeReg;
  logic [15:0] wdataReg;
  logic        accept, badAlign, badRange, isFault, isWordStore;
  logic [32:0] lastByte;
  logic [7:0]  byteLane;
  logic [15:0] halfLane;
  logic [31:0] loadValue, mergedWord;

  assign accept      = req_valid && (state == IDLE);
  assign isWordStore = req_write && (req_size == 2'b10);
  assign badAlign    = (req_size == 2'b11) ||
                       ((req_size == 2'b01) && req_addr[0]) ||
                       ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  assign lastByte    = {1'b0, req_addr[31:2], 2'b00} + 33'd3;
  assign badRange    = lastByte >= 33'(MEM_BYTES);
  assign isFault     = badAlign || badRange;

  assign req_ready = (state == IDLE);
  assign mem_read  = state[1];
  assign mem_write = state[2];

  // Lane 0 is the most significant byte of the word.
  always_comb begin
    byteLane = 8'h00;
    case (offsetReg)
      2'd0:    byteLane = mem_readData[31:24];
      2'd1:    byteLane = mem_readData[23:16];
      2'd2:    byteLane = mem_readData[15:8];
      default: byteLane = mem_readData[7:0];
    endcase
    halfLane = offsetReg[1] ? mem_readData[15:0] : mem_readData[31:16];
  end

  always_comb begin
    loadValue = 32'h0;
    case (sizeReg)
      2'b00:   loadValue = {{24{signedReg & byteLane[7]}}, byteLane};
      2'b01:   loadValue = {{16{signedReg & halfLane[15]}}, halfLane};
      default: loadValue = mem_readData;
    endcase
  end

  always_comb begin
    mergedWord = mem_readData;
    if (sizeReg == 2'b00) begin
      case (offsetReg)
        2'd0:    mergedWord[31:24] = wdataReg[7:0];
        2'd1:    mergedWord[23:16] = wdataReg[7:0];
        2'd2:    mergedWord[15:8]  = wdataReg[7:0];
        default: mergedWord[7:0]   = wdataReg[7:0];
      endcase
    end else if (offsetReg[1]) begin
      mergedWord[15:0] = wdataReg;
    end else begin
      mergedWord[31:16] = wdataReg;
    end
  end

  always_comb begin
    stateNext     = state;
    respValidNext = 1'b0;
    faultNext     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (isFault)          faultNext = 1'b1;
          else if (isWordStore) stateNext = WR;
          else                  stateNext = RD;
        end
      end
      RD:  stateNext = MRG;
      MRG: begin
        if (writeReg) begin
          stateNext = WR;
        end else begin
          stateNext     = IDLE;
          respValidNext = 1'b1;
        end
      end
      WR: begin
        stateNext     = IDLE;
        respValidNext = 1'b1;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= stateNext;
      resp_valid <= respValidNext;
      fault      <= faultNext;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      offsetReg     <= 2'b00;
      sizeReg       <= 2'b00;
      signedReg     <= 1'b0;
      writeReg      <= 1'b0;
      wdataReg      <= 16'h0;
      resp_rdata    <= 32'h0;
      mem_address   <= 32'h0;
      mem_writeData <= 32'h0;
    end else begin
      if (accept && !isFault) begin
        offsetReg   <= req_addr[1:0];
        sizeReg     <= req_size;
        signedReg   <= req_signed;
        writeReg    <= req_write;
        wdataReg    <= req_wdata[15:0];
        mem_address <= {req_addr[31:2], 2'b00};
        if (isWordStore) mem_writeData <= req_wdata;
      end
      if (state == MRG) begin
        if (writeReg) mem_writeData <= mergedWord;
        else          resp_rdata    <= loadValue;
      end
    end
  end

endmodule
